// File: rtl/servo_pwm_core.sv
// Servo PWM generator: programmable period/pulse with per-period slew toward the target.
// Pulse and period changes only take effect at a period boundary, so the output never glitches mid-period.
module servo_pwm_core #(
  parameter int CNT_W  = 24,
  parameter int STEP_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              enable,
  input  logic              cfg_wr,
  input  logic [CNT_W-1:0]  period_in,
  input  logic [CNT_W-1:0]  pulse_in,
  input  logic [STEP_W-1:0] step_in,
  output logic              pwm_out,
  output logic              period_start,
  output logic [CNT_W-1:0]  cur_pulse,
  output logic              at_target,
  output logic              running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    active_period;
  logic [CNT_W-1:0]    pending_period;
  logic [CNT_W-1:0]    pending_pulse;
  logic [STEP_W-1:0]   pending_step;

  logic [CNT_W-1:0]    eff_period;
  logic [CNT_W-1:0]    eff_target;
  logic                wrap;
  logic [CNT_W:0]      cur_ext, tgt_ext, step_ext, diff, delta, nxt_ext;
  logic [CNT_W-1:0]    slew_pulse;

  always_comb begin
    eff_period = (pending_period < CNT_W'(2)) ? CNT_W'(2) : pending_period;
    eff_target = (pending_pulse < eff_period) ? pending_pulse : eff_period;
    at_target  = (cur_pulse == eff_target);
    running    = (state == RUN);
    wrap       = (cnt == active_period - CNT_W'(1));
  end

  // Slew in CNT_W+1 bits: delta never exceeds the distance, so no overshoot or wrap.
  always_comb begin
    cur_ext  = {1'b0, cur_pulse};
    tgt_ext  = {1'b0, eff_target};
    step_ext = {{(CNT_W+1-STEP_W){1'b0}}, pending_step};
    diff     = (tgt_ext > cur_ext) ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);
    delta    = (step_ext < diff) ? step_ext : diff;
    nxt_ext  = (tgt_ext > cur_ext) ? (cur_ext + delta) : (cur_ext - delta);
    if (pending_step == '0 || nxt_ext[CNT_W])
      slew_pulse = eff_target;
    else
      slew_pulse = nxt_ext[CNT_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (wrap && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt            <= '0;
      active_period  <= '0;
      cur_pulse      <= '0;
      pwm_out        <= 1'b0;
      period_start   <= 1'b0;
      pending_period <= '0;
      pending_pulse  <= '0;
      pending_step   <= '0;
    end else begin
      if (cfg_wr) begin
        pending_period <= period_in;
        pending_pulse  <= pulse_in;
        pending_step   <= step_in;
      end
      pwm_out      <= (state == RUN) && (cnt < cur_pulse);
      period_start <= (state == RUN) && (cnt == '0);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable) begin
            active_period <= eff_period;
            cur_pulse     <= eff_target;
          end
        end
        RUN: begin
          if (wrap) begin
            cnt <= '0;
            // Stopping keeps the last applied pulse; the next start reloads the target directly.
            if (enable) begin
              active_period <= eff_period;
              cur_pulse     <= slew_pulse;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_core.sv
// Directed bench for servo_pwm_core: period/pulse shape, slew, clamps, boundary config, stop and async reset.
module tb_servo_pwm_core;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [23:0] period_in = '0;
  logic [23:0] pulse_in = '0;
  logic [15:0] step_in = '0;
  logic        pwm_out, period_start, at_target, running;
  logic [23:0] cur_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  servo_pwm_core #(.CNT_W(24), .STEP_W(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .cfg_wr(cfg_wr),
    .period_in(period_in), .pulse_in(pulse_in), .step_in(step_in),
    .pwm_out(pwm_out), .period_start(period_start), .cur_pulse(cur_pulse),
    .at_target(at_target), .running(running)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; the strobe is captured on the following rising edge.
  task automatic cfg(input int per, input int pul, input int stp);
    period_in = 24'(per);
    pulse_in  = 24'(pul);
    step_in   = 16'(stp);
    cfg_wr    = 1'b1;
    @(negedge ACLK);
    cfg_wr    = 1'b0;
  endtask

  task automatic wait_ps();
    int k = 0;
    while (period_start !== 1'b1 && k < 40) begin
      @(negedge ACLK);
      k++;
    end
    if (k == 40) check("ps_timeout", {31'd0, period_start}, 1);
  endtask

  // Checks one full period starting at the cycle where period_start is shown.
  task automatic run_period(input int high, input int per, input logic at);
    wait_ps();
    check("cur_pulse", cur_pulse, high);
    check("at_target", {31'd0, at_target}, {31'd0, at});
    check("running", {31'd0, running}, 1);
    for (int i = 0; i < per; i++) begin
      check("pwm", {31'd0, pwm_out}, (i < high) ? 1 : 0);
      check("period_start", {31'd0, period_start}, (i == 0) ? 1 : 0);
      @(negedge ACLK);
    end
  endtask

  initial begin
    logic act;
    // Reset state
    #2;
    check("rst_pwm", {31'd0, pwm_out}, 0);
    check("rst_ps", {31'd0, period_start}, 0);
    check("rst_running", {31'd0, running}, 0);
    check("rst_cur", cur_pulse, 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    check("idle_running", {31'd0, running}, 0);

    // 3 high / 7 low, period_start every 10
    cfg(10, 3, 0);
    enable = 1'b1;
    run_period(3, 10, 1'b1);
    run_period(3, 10, 1'b1);

    // Slew by 1 per period
    cfg(10, 2, 1);
    run_period(2, 10, 1'b1);
    cfg(10, 5, 1);
    check("at_target_pre", {31'd0, at_target}, 0);
    run_period(3, 10, 1'b0);
    run_period(4, 10, 1'b0);
    run_period(5, 10, 1'b1);

    // Zero pulse, pulse clamped to period, period clamped to 2
    cfg(10, 0, 0);
    run_period(0, 10, 1'b1);
    cfg(10, 12, 0);
    run_period(10, 10, 1'b1);
    cfg(1, 5, 0);
    run_period(2, 2, 1'b1);
    cfg(10, 4, 0);          // lands on the wrap edge of the 2-cycle period
    run_period(2, 2, 1'b0);
    run_period(4, 10, 1'b1);

    // Config exactly on the wrap edge of a 10-cycle period
    repeat (8) @(negedge ACLK);
    cfg(6, 1, 0);
    run_period(4, 10, 1'b0);
    run_period(1, 6, 1'b1);

    // Stop request at cnt=4 completes the period then idles
    cfg(10, 3, 0);
    run_period(3, 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stop_pwm", {31'd0, pwm_out}, (i < 3) ? 1 : 0);
      if (i == 3) enable = 1'b0;
      if (i == 8) check("stop_running_hi", {31'd0, running}, 1);
      if (i == 9) check("stop_running_lo", {31'd0, running}, 0);
      @(negedge ACLK);
    end
    check("idle_pwm", {31'd0, pwm_out}, 0);
    check("idle_ps", {31'd0, period_start}, 0);
    act = 1'b0;
    repeat (15) begin
      @(negedge ACLK);
      act = act | pwm_out | period_start | running;
    end
    check("idle_quiet", {31'd0, act}, 0);

    // Async reset during high phase
    cfg(10, 5, 0);
    enable = 1'b1;
    wait_ps();
    check("pre_rst_pwm", {31'd0, pwm_out}, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("async_pwm", {31'd0, pwm_out}, 0);
    check("async_ps", {31'd0, period_start}, 0);
    check("async_running", {31'd0, running}, 0);
    check("async_cur", cur_pulse, 0);
    check("async_at_target", {31'd0, at_target}, 1);
    enable = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    act = 1'b0;
    repeat (5) begin
      @(negedge ACLK);
      act = act | pwm_out | period_start | running;
    end
    check("post_rst_quiet", {31'd0, act}, 0);
    enable = 1'b1;
    @(negedge ACLK);
    check("restart_running", {31'd0, running}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_pwm_core.md
SERVO_PWM_CORE -- requirements
Module: servo_pwm_core

Interface
REQ-001 Parameter CNT_W, default 24, width of the period and pulse counters in clock cycles.
REQ-002 Parameter STEP_W, default 16, width of the slew step.
REQ-003 ACLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 enable  in  1  run request from the control register.
REQ-006 cfg_wr  in  1  single-cycle strobe that captures period_in, pulse_in and step_in into pending registers.
REQ-007 period_in  in  CNT_W  PWM period in cycles.
REQ-008 pulse_in  in  CNT_W  target high time in cycles.
REQ-009 step_in  in  STEP_W  maximum pulse change per period; 0 means unlimited.
REQ-010 pwm_out  out  1  servo drive signal, registered.
REQ-011 period_start  out  1  one-cycle pulse at the first cycle of every period.
REQ-012 cur_pulse  out  CNT_W  high time applied in the current period.
REQ-013 at_target  out  1  high when cur_pulse equals the clamped target.
REQ-014 running  out  1  high while in RUN.

Function
REQ-015 The block SHALL have two states: IDLE and RUN.
REQ-016 On cfg_wr, pending_period, pending_pulse and pending_step SHALL update on that edge; the new values are visible from the next cycle.
REQ-017 A period boundary coinciding with cfg_wr SHALL use the old pending values.
REQ-018 Effective period SHALL be max(pending_period, 2); effective target SHALL be min(pending_pulse, effective period).
REQ-019 IDLE, enable=1: the block SHALL go to RUN, set cnt=0, latch the active period, and load cur_pulse directly to the effective target with no slew.
REQ-020 IDLE: pwm_out=0, period_start=0, cnt held at 0.
REQ-021 RUN: cnt SHALL increment each cycle from 0 to active_period-1, then wrap to 0.
REQ-022 pwm_out(t+1) SHALL equal (cnt(t) < cur_pulse(t)), giving exactly cur_pulse high cycles followed by active_period-cur_pulse low cycles.
REQ-023 period_start SHALL be registered and asserted in the cycle where pwm_out reflects cnt=0.
REQ-024 At wrap (cnt = active_period-1), the block SHALL reload active_period from the pending registers.
REQ-025 At wrap, if step=0, cur_pulse SHALL be set to the target.
REQ-026 At wrap, if step≠0, cur_pulse SHALL move toward the target by min(step, |target-cur_pulse|).
REQ-027 Slew arithmetic SHALL be unsigned, use CNT_W+1 bit intermediates, and never overshoot or wrap.
REQ-028 cur_pulse and active_period SHALL be constant within a period; there are no mid-period glitches.
REQ-029 If cur_pulse=0, pwm_out SHALL be constantly low; if cur_pulse ≥ active_period, pwm_out SHALL be constantly high across the whole period.
REQ-030 If enable=0 in RUN, the current period SHALL complete; at wrap the block SHALL enter IDLE and not start a new period.
REQ-031 If enable reasserts before the wrap, the block SHALL stay in RUN.
REQ-032 cur_pulse SHALL be retained in IDLE.
REQ-033 at_target SHALL be combinational from cur_pulse and the clamped target.

Reset
REQ-034 ARESETN low SHALL asynchronously force: state=IDLE, cnt=0, pwm_out=0, period_start=0, cur_pulse=0, pending_period=0, pending_pulse=0, pending_step=0, running=0.
REQ-035 Reset asserted mid-period SHALL drop pwm_out to 0 immediately, without waiting for a clock edge.
REQ-036 After ARESETN rises, the block SHALL stay in IDLE until enable is sampled high.

Verification
REQ-037 cfg_wr period=10, pulse=3, step=0, then enable=1 -> pwm_out repeats 3 high / 7 low; period_start every 10 cycles; at_target=1.
REQ-038 Running period=10, pulse=2, step=1; cfg_wr pulse=5 -> cur_pulse 3, 4, 5 on successive periods; at_target rises with the period that applies 5.
REQ-039 cfg_wr pulse=0 -> pwm_out constantly low; cfg_wr pulse=12 with period=10 -> pwm_out constantly high, cur_pulse=10.
REQ-040 cfg_wr on the same cycle as a wrap -> that next period uses the old values; the following period uses the new values.
REQ-041 enable=0 at cnt=4 of a 10-cycle period -> the remaining period completes; the block enters IDLE, pwm_out=0, running=0.
REQ-042 ARESETN low during the high phase -> pwm_out=0 with no clock edge; all outputs at reset values; no activity until enable=1.
